// File: rtl/sram_rowk_mp.sv
// rtl/sram_rowk_mp.sv - row/column addressed SRAM with parallel read channels and a clear sequencer
module sram_rowk_mp #(
   parameter int M               = 8,
   parameter int KMAX            = 1024,
   parameter int DATA_W          = 32,
   parameter int NRD             = 2,
   parameter int RD_LAT          = 1,
   parameter int CONFLICT_POLICY = 1,
   localparam int BYTE_W = DATA_W / 8,
   localparam int ROW_W  = (M > 1) ? $clog2(M) : 1,
   localparam int K_W    = (KMAX > 1) ? $clog2(KMAX) : 1,
   localparam int DEPTH  = M * KMAX,
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    w_valid,
   output logic                    w_ready,
   input  logic [ROW_W-1:0]        w_row,
   input  logic [K_W-1:0]          w_k,
   input  logic [DATA_W-1:0]       w_wdata,
   input  logic [BYTE_W-1:0]       w_wmask,
   input  logic [NRD-1:0]          r_valid,
   output logic [NRD-1:0]          r_ready,
   input  logic [NRD*ROW_W-1:0]    r_row,
   input  logic [NRD*K_W-1:0]      r_k,
   output logic [NRD*DATA_W-1:0]   rd_data,
   output logic [NRD-1:0]          rd_valid,
   output logic [NRD-1:0]          rd_err,
   input  logic                    clr_start,
   input  logic                    clr_all,
   input  logic [ROW_W-1:0]        clr_row,
   output logic                    clr_busy,
   output logic                    clr_done,
   output logic                    err_sticky,
   input  logic                    err_clr
);

   typedef enum logic [1:0] {S_IDLE, S_CLR, S_DONE} state_t;

   // One extra bit so M and KMAX compare correctly when they are powers of two
   localparam logic [ROW_W:0] M_L = (ROW_W+1)'(M);
   localparam logic [K_W:0]   K_L = (K_W+1)'(KMAX);

   function automatic logic row_oob(input logic [ROW_W-1:0] row);
      return {1'b0, row} >= M_L;
   endfunction

   function automatic logic k_oob(input logic [K_W-1:0] k);
      return {1'b0, k} >= K_L;
   endfunction

   function automatic logic [ADDR_W-1:0] addr_of(input logic [ROW_W-1:0] row, input logic [K_W-1:0] k);
      return ADDR_W'(row) * ADDR_W'(KMAX) + ADDR_W'(k);
   endfunction

   function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                               input logic [DATA_W-1:0] wd,
                                               input logic [BYTE_W-1:0] mask);
      logic [DATA_W-1:0] r;
      r = old_w;
      for (int b = 0; b < BYTE_W; b++)
         if (mask[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   logic [DATA_W-1:0] mem [DEPTH];
   state_t            state, state_n;
   logic [ADDR_W-1:0] clr_addr, clr_addr_n, clr_end, clr_end_n;
   logic              clr_we, clr_err;
   logic              w_fire, w_oob, err_set;
   logic [ADDR_W-1:0] w_addr;
   logic [NRD-1:0]    c_v, c_e, p_v, p_e, s_v, s_e;
   logic [NRD*DATA_W-1:0] c_d, p_d, s_d;

   assign clr_busy = (state != S_IDLE);
   assign clr_done = (state == S_DONE);
   assign w_ready  = ~clr_busy;
   assign r_ready  = {NRD{~clr_busy}};
   assign w_fire   = w_valid & w_ready;
   assign w_oob    = row_oob(w_row) | k_oob(w_k);
   assign w_addr   = addr_of(w_row, w_k);

   always_ff @(posedge clk) begin
      if (clr_we)
         mem[clr_addr] <= '0;
      else if (w_fire && !w_oob)
         mem[w_addr] <= merge(mem[w_addr], w_wdata, w_wmask);
   end

   // Read words are taken at the fire edge; write-first merges the concurrent write
   always_comb begin
      logic [ROW_W-1:0]  rr;
      logic [K_W-1:0]    rk;
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd_word;
      rr = '0;
      rk = '0;
      ra = '0;
      rd_word = '0;
      c_v = r_valid & r_ready;
      c_e = '0;
      c_d = '0;
      for (int i = 0; i < NRD; i++) begin
         rr = r_row[i*ROW_W +: ROW_W];
         rk = r_k[i*K_W +: K_W];
         ra = addr_of(rr, rk);
         c_e[i] = row_oob(rr) | k_oob(rk);
         if (!c_e[i]) begin
            rd_word = mem[ra];
            if (CONFLICT_POLICY != 0 && w_fire && !w_oob && ra == w_addr)
               rd_word = merge(rd_word, w_wdata, w_wmask);
            c_d[i*DATA_W +: DATA_W] = rd_word;
         end
      end
   end

   assign s_v = (RD_LAT == 2) ? p_v : c_v;
   assign s_e = (RD_LAT == 2) ? p_e : c_e;
   assign s_d = (RD_LAT == 2) ? p_d : c_d;
   assign err_set = (w_fire & w_oob) | (|(c_v & c_e)) | clr_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_v        <= '0;
         p_e        <= '0;
         p_d        <= '0;
         rd_valid   <= '0;
         rd_err     <= '0;
         rd_data    <= '0;
         err_sticky <= 1'b0;
      end else begin
         p_v        <= c_v;
         p_e        <= c_e;
         p_d        <= c_d;
         rd_valid   <= s_v;
         rd_err     <= s_v & s_e;
         err_sticky <= err_set | (err_sticky & ~err_clr);
         for (int i = 0; i < NRD; i++)
            if (s_v[i]) rd_data[i*DATA_W +: DATA_W] <= s_d[i*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         clr_addr <= '0;
         clr_end  <= '0;
      end else begin
         state    <= state_n;
         clr_addr <= clr_addr_n;
         clr_end  <= clr_end_n;
      end
   end

   always_comb begin
      state_n    = state;
      clr_addr_n = clr_addr;
      clr_end_n  = clr_end;
      clr_we     = 1'b0;
      clr_err    = 1'b0;
      case (state)
         S_IDLE: begin
            if (clr_start) begin
               if (clr_all) begin
                  clr_addr_n = '0;
                  clr_end_n  = ADDR_W'(DEPTH - 1);
                  state_n    = S_CLR;
               end else if (row_oob(clr_row)) begin
                  clr_err = 1'b1;
                  state_n = S_DONE;
               end else begin
                  clr_addr_n = addr_of(clr_row, K_W'(0));
                  clr_end_n  = addr_of(clr_row, K_W'(0)) + ADDR_W'(KMAX - 1);
                  state_n    = S_CLR;
               end
            end
         end
         S_CLR: begin
            clr_we = 1'b1;
            if (clr_addr == clr_end) state_n = S_DONE;
            else clr_addr_n = clr_addr + ADDR_W'(1);
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_sram_rowk_mp.sv
// tb/tb_sram_rowk_mp.sv - randomized bench for sram_rowk_mp against a cycle-scheduled behavioural model
module tb_sram_rowk_mp;
   localparam int M = 5, KMAX = 12, DATA_W = 32, NRD = 2, RD_LAT = 2, POL = 1;
   localparam int BYTE_W = 4, ROW_W = 3, K_W = 4, DEPTH = M * KMAX;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic w_valid, w_ready;
   logic [ROW_W-1:0] w_row;
   logic [K_W-1:0] w_k;
   logic [DATA_W-1:0] w_wdata;
   logic [BYTE_W-1:0] w_wmask;
   logic [NRD-1:0] r_valid, r_ready, rd_valid, rd_err;
   logic [NRD*ROW_W-1:0] r_row;
   logic [NRD*K_W-1:0] r_k;
   logic [NRD*DATA_W-1:0] rd_data;
   logic clr_start, clr_all, clr_busy, clr_done, err_sticky, err_clr;
   logic [ROW_W-1:0] clr_row;

   sram_rowk_mp #(.M(M), .KMAX(KMAX), .DATA_W(DATA_W), .NRD(NRD), .RD_LAT(RD_LAT),
                  .CONFLICT_POLICY(POL)) dut (
      .clk(clk), .rst_n(rst_n), .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
      .w_k(w_k), .w_wdata(w_wdata), .w_wmask(w_wmask), .r_valid(r_valid), .r_ready(r_ready),
      .r_row(r_row), .r_k(r_k), .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
      .clr_start(clr_start), .clr_all(clr_all), .clr_row(clr_row), .clr_busy(clr_busy),
      .clr_done(clr_done), .err_sticky(err_sticky), .err_clr(err_clr));

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   // Model state: word array, clear window, sticky error, results scheduled by due cycle
   logic [DATA_W-1:0] mm [DEPTH];
   bit   clr_act, m_err;
   int   t0, clr_n, clr_lo;
   int   edue [NRD][8];
   logic [DATA_W-1:0] ed [NRD][8];
   logic ee [NRD][8];
   logic [DATA_W-1:0] m_hold [NRD];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] bmerge(input logic [DATA_W-1:0] o,
                                                input logic [DATA_W-1:0] d,
                                                input logic [BYTE_W-1:0] m);
      logic [DATA_W-1:0] r;
      r = o;
      for (int b = 0; b < BYTE_W; b++)
         if (m[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic bit m_busy(input int c);
      return clr_act && (c >= t0) && (c <= t0 + clr_n);
   endfunction

   task automatic model_reset();
      clr_act = 0;
      m_err = 0;
      t0 = 0;
      clr_n = 0;
      clr_lo = 0;
      for (int ch = 0; ch < NRD; ch++)
         for (int s = 0; s < 8; s++) edue[ch][s] = -1;
   endtask

   task automatic model_step();
      bit rdy, wf, woob, nerr;
      int wa, due, s, j;
      rdy  = !m_busy(cyc - 1);
      nerr = 0;
      wf   = w_valid && rdy;
      woob = (int'(w_row) >= M) || (int'(w_k) >= KMAX);
      wa   = int'(w_row) * KMAX + int'(w_k);
      due  = cyc + RD_LAT - 1;
      s    = due % 8;
      for (int ch = 0; ch < NRD; ch++) begin
         if (r_valid[ch] && rdy) begin
            int rr, rk, ra;
            logic [DATA_W-1:0] d;
            rr = int'(r_row[ch*ROW_W +: ROW_W]);
            rk = int'(r_k[ch*K_W +: K_W]);
            ra = rr * KMAX + rk;
            edue[ch][s] = due;
            if (rr >= M || rk >= KMAX) begin
               ed[ch][s] = '0;
               ee[ch][s] = 1'b1;
               nerr = 1;
            end else begin
               d = mm[ra];
               if (POL != 0 && wf && !woob && ra == wa) d = bmerge(d, w_wdata, w_wmask);
               ed[ch][s] = d;
               ee[ch][s] = 1'b0;
            end
         end
      end
      if (wf) begin
         if (woob) nerr = 1;
         else mm[wa] = bmerge(mm[wa], w_wdata, w_wmask);
      end
      j = cyc - t0 - 1;
      if (clr_act && j >= 0 && j < clr_n) mm[clr_lo + j] = '0;
      if (clr_start && rdy) begin
         t0 = cyc;
         clr_act = 1;
         if (clr_all) begin
            clr_lo = 0;
            clr_n = DEPTH;
         end else if (int'(clr_row) >= M) begin
            clr_lo = 0;
            clr_n = 0;
            nerr = 1;
         end else begin
            clr_lo = int'(clr_row) * KMAX;
            clr_n = KMAX;
         end
      end
      m_err = nerr || (m_err && !err_clr);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mm[i] = '0;
      model_reset();
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            for (int ch = 0; ch < NRD; ch++) m_hold[ch] = '0;
            chk("reset rd_valid", 64'(rd_valid), 0);
            chk("reset rd_err", 64'(rd_err), 0);
            chk("reset rd_data", 64'(rd_data), 0);
            chk("reset clr_busy", 64'(clr_busy), 0);
            chk("reset clr_done", 64'(clr_done), 0);
            chk("reset err_sticky", 64'(err_sticky), 0);
         end else begin
            int s;
            s = cyc % 8;
            chk("clr_busy", 64'(clr_busy), 64'(m_busy(cyc)));
            chk("clr_done", 64'(clr_done), 64'(clr_act && cyc == t0 + clr_n));
            chk("err_sticky", 64'(err_sticky), 64'(m_err));
            chk("w_ready", 64'(w_ready), 64'(!m_busy(cyc)));
            chk("r_ready", 64'(r_ready), m_busy(cyc) ? 64'd0 : 64'((1 << NRD) - 1));
            for (int ch = 0; ch < NRD; ch++) begin
               bit ev;
               ev = (edue[ch][s] == cyc);
               chk($sformatf("rd_valid[%0d]", ch), 64'(rd_valid[ch]), 64'(ev));
               if (ev) begin
                  m_hold[ch] = ed[ch][s];
                  chk($sformatf("rd_err[%0d]", ch), 64'(rd_err[ch]), 64'(ee[ch][s]));
               end
               chk($sformatf("rd_data[%0d]", ch), 64'(rd_data[ch*DATA_W +: DATA_W]), 64'(m_hold[ch]));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      w_valid = 0; w_row = '0; w_k = '0; w_wdata = '0; w_wmask = '0;
      r_valid = '0; r_row = '0; r_k = '0;
      clr_start = 0; clr_all = 0; clr_row = '0; err_clr = 0;
   endtask

   task automatic do_write(input int row, input int k, input logic [DATA_W-1:0] d, input logic [BYTE_W-1:0] m);
      w_valid = 1; w_row = ROW_W'(row); w_k = K_W'(k); w_wdata = d; w_wmask = m;
      tick();
      w_valid = 0;
   endtask

   task automatic do_read(input int ch, input int row, input int k, output logic [DATA_W-1:0] d, output logic e);
      int lat;
      r_valid[ch] = 1'b1;
      r_row[ch*ROW_W +: ROW_W] = ROW_W'(row);
      r_k[ch*K_W +: K_W] = K_W'(k);
      tick();
      r_valid = '0;
      w_valid = 0;
      lat = 1;
      for (int n = 0; n < 6 && !rd_valid[ch]; n++) begin
         tick();
         lat++;
      end
      chk("read latency", rd_valid[ch] ? 64'(lat) : 64'd99, 64'(RD_LAT));
      d = rd_data[ch*DATA_W +: DATA_W];
      e = rd_err[ch];
   endtask

   task automatic wait_clear(input int budget, output int nb, output int nd);
      nb = 0;
      nd = 0;
      for (int i = 0; i < budget; i++) begin
         if (!clr_busy) break;
         nb++;
         if (clr_done) nd++;
         tick();
      end
   endtask

   task automatic start_clear(input bit all, input int row);
      clr_start = 1; clr_all = all; clr_row = ROW_W'(row);
      tick();
      clr_start = 0; clr_all = 0;
   endtask

   initial begin
      logic [DATA_W-1:0] d;
      logic e;
      int nb, nd;
      idle_inputs();
      repeat (3) tick();
      chk("lit reset rd_valid", 64'(rd_valid), 0);
      chk("lit reset clr_busy", 64'(clr_busy), 0);
      rst_n = 1;
      tick();

      start_clear(1, 0);
      wait_clear(DEPTH + 10, nb, nd);
      chk("clr_all busy cycles", 64'(nb), 64'(DEPTH + 1));
      chk("clr_all done pulses", 64'(nd), 1);

      do_write(2, 5, 32'hDEADBEEF, 4'hF);
      do_read(0, 2, 5, d, e);
      chk("basic rd_data", 64'(d), 64'hDEADBEEF);
      chk("basic rd_err", 64'(e), 0);

      do_write(1, 1, 32'h11223344, 4'hF);
      do_write(1, 1, 32'hAABBCCDD, 4'b0101);
      do_read(1, 1, 1, d, e);
      chk("byte mask merge", 64'(d), 64'h11BB33DD);

      do_write(0, 0, 32'h5, 4'hF);
      w_valid = 1; w_row = '0; w_k = '0; w_wdata = '0; w_wmask = 4'hF;
      do_read(0, 0, 0, d, e);
      chk("same-cycle conflict", 64'(d), (POL != 0) ? 64'h0 : 64'h5);

      do_write(1, 0, 32'h0A0A0A0A, 4'hF);
      do_write(0, 12, 32'h0BAD0BAD, 4'hF);
      do_read(0, 1, 0, d, e);
      chk("oob write dropped", 64'(d), 64'h0A0A0A0A);

      do_write(3, 4, 32'h1234, 4'hF);
      do_write(3, 11, 32'h77, 4'hF);
      start_clear(0, 3);
      wait_clear(KMAX + 10, nb, nd);
      chk("row clear busy cycles", 64'(nb), 64'(KMAX + 1));
      chk("row clear done pulses", 64'(nd), 1);
      do_read(0, 3, 4, d, e);
      chk("cleared row k4", 64'(d), 0);
      do_read(1, 3, 11, d, e);
      chk("cleared row k11", 64'(d), 0);
      do_read(0, 2, 5, d, e);
      chk("neighbour row intact", 64'(d), 64'hDEADBEEF);

      do_read(1, M, 0, d, e);
      chk("oob read data", 64'(d), 0);
      chk("oob read err", 64'(e), 1);
      chk("oob read sticky", 64'(err_sticky), 1);
      err_clr = 1; tick(); err_clr = 0;
      chk("err_clr clears", 64'(err_sticky), 0);
      err_clr = 1; w_valid = 1; w_row = 3'd7; w_k = '0;
      tick();
      err_clr = 0; w_valid = 0;
      chk("err_clr with new error", 64'(err_sticky), 1);
      err_clr = 1; tick(); err_clr = 0;

      start_clear(0, 6);
      chk("bad clr_row done", 64'(clr_done), 1);
      chk("bad clr_row sticky", 64'(err_sticky), 1);
      tick();
      chk("bad clr_row idle", 64'(clr_busy), 0);

      do_write(4, 0, 32'hCAFE, 4'hF);
      do_write(4, 8, 32'hBEEF, 4'hF);
      start_clear(0, 4);
      repeat (3) tick();
      rst_n = 0;
      #1;
      chk("abort clr_busy", 64'(clr_busy), 0);
      chk("abort err_sticky", 64'(err_sticky), 0);
      chk("abort rd_data", 64'(rd_data), 0);
      tick();
      rst_n = 1;
      tick();
      do_read(0, 4, 0, d, e);
      chk("aborted clear word zero", 64'(d), 0);
      do_read(1, 4, 8, d, e);
      chk("aborted clear word kept", 64'(d), 64'hBEEF);
      start_clear(0, 4);
      chk("restart accepted", 64'(clr_busy), 1);
      wait_clear(KMAX + 10, nb, nd);
      chk("restart done pulses", 64'(nd), 1);
      do_read(1, 4, 8, d, e);
      chk("restart cleared", 64'(d), 0);

      for (int it = 0; it < 3000; it++) begin
         w_valid = ($urandom % 3) == 0;
         w_row = ROW_W'($urandom_range(0, 6));
         w_k = K_W'($urandom_range(0, 13));
         w_wdata = $urandom;
         w_wmask = BYTE_W'($urandom);
         for (int ch = 0; ch < NRD; ch++) begin
            r_valid[ch] = ($urandom % 2) == 0;
            if (($urandom % 4) == 0) begin
               r_row[ch*ROW_W +: ROW_W] = w_row;
               r_k[ch*K_W +: K_W] = w_k;
            end else begin
               r_row[ch*ROW_W +: ROW_W] = ROW_W'($urandom_range(0, 6));
               r_k[ch*K_W +: K_W] = K_W'($urandom_range(0, 13));
            end
         end
         clr_start = ($urandom % 60) == 0;
         clr_all = ($urandom % 8) == 0;
         clr_row = ROW_W'($urandom_range(0, 6));
         err_clr = ($urandom % 10) == 0;
         tick();
      end
      idle_inputs();
      wait_clear(DEPTH + 10, nb, nd);
      chk("final idle", 64'(clr_busy), 0);
      repeat (4) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sram_rowk_mp.md
SRAM_ROWK_MP -- requirements
Module: sram_rowk_mp

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
  M, 8, number of rows
  KMAX, 1024, words per row
  DATA_W, 32, word width (multiple of 8)
  NRD, 2, independent read channels
  RD_LAT, 1, read latency in cycles (1 or 2)
  CONFLICT_POLICY, 1, same-address read/write: 0 read-old, 1 write-first
REQ-002 SHALL derive BYTE_W=DATA_W/8, ROW_W=max(1,clog2(M)), K_W=max(1,clog2(KMAX)), DEPTH=M*KMAX, ADDR_W=max(1,clog2(DEPTH)).
REQ-003 SHALL have ports, one per line: name  direction  width  meaning:
  clk  in  1  single clock; all logic on rising edge
  rst_n  in  1  reset, asynchronous, active-low
  w_valid  in  1  write request
  w_ready  out  1  write accept
  w_row  in  ROW_W  write row
  w_k  in  K_W  write column
  w_wdata  in  DATA_W  write data
  w_wmask  in  BYTE_W  byte enables, bit b covers bits 8b+7:8b
  r_valid  in  NRD  per-channel read request
  r_ready  out  NRD  per-channel read accept
  r_row  in  NRD*ROW_W  read rows, channel i in slice i
  r_k  in  NRD*K_W  read columns, channel i in slice i
  rd_data  out  NRD*DATA_W  read data
  rd_valid  out  NRD  read data valid pulse
  rd_err  out  NRD  returned read was out of range
  clr_start  in  1  start clear sequence
  clr_all  in  1  sampled with clr_start: 1 clears all rows
  clr_row  in  ROW_W  sampled with clr_start: row to clear
  clr_busy  out  1  clear in progress
  clr_done  out  1  one-cycle completion pulse
  err_sticky  out  1  latched out-of-range access
  err_clr  in  1  clears err_sticky

Function
REQ-004 SHALL map (row,k) to address row*KMAX+k, computed at ADDR_W width.
REQ-005 SHALL drive w_ready and all r_ready bits as !clr_busy; a request fires when valid && ready.
REQ-006 SHALL apply a fired write at the clock edge, updating only bytes with w_wmask set; w_wmask=0 leaves the word unchanged.
REQ-007 SHALL serve all NRD read channels in the same cycle with no mutual stall; rd_valid[i] pulses exactly RD_LAT cycles after channel i fires; each fire yields exactly one pulse.
REQ-008 SHALL hold rd_data[i] from the last valid read until the next rd_valid[i].
REQ-009 SHALL, when a read and a write fire to the same address in one cycle, return the pre-write word if CONFLICT_POLICY=0, or the byte-merged post-write word if CONFLICT_POLICY=1.
REQ-010 SHALL treat row>=M or k>=KMAX as out of range: a write is dropped; a read returns rd_data=0 with rd_err=1 and normal rd_valid timing; both set err_sticky.
REQ-011 SHALL clear err_sticky on err_clr; if err_clr and a new error occur in the same cycle, err_sticky SHALL be 1.
REQ-012 SHALL implement clear FSM IDLE->CLR->DONE->IDLE: clr_start in IDLE latches range (all DEPTH words, or KMAX words of clr_row) and enters CLR.
REQ-013 SHALL, in CLR, write zero to one address per cycle in ascending order, then enter DONE after the last address; DONE asserts clr_done for one cycle and returns to IDLE.
REQ-014 SHALL assert clr_busy in CLR and DONE; clr_start outside IDLE is ignored.
REQ-015 SHALL, for clr_start with clr_all=0 and clr_row>=M, set err_sticky, assert clr_done next cycle, and write nothing.
REQ-016 SHALL complete reads that fired before clr_busy rose; read data reflects memory at the fire edge.

Reset
REQ-017 SHALL on rst_n low drive rd_valid=0, rd_err=0, rd_data=0, clr_busy=0, clr_done=0, err_sticky=0, FSM=IDLE, and flush the read pipeline.
REQ-018 SHALL not initialise memory contents; reset during CLR aborts it, leaving cleared words zero and others unchanged.

Verification
REQ-019 SHALL cover: write row 2,k 5 data 0xDEADBEEF mask 0xF, then read ch0 -> rd_valid[0] at +RD_LAT, rd_data=0xDEADBEEF.
REQ-020 SHALL cover: over 0x11223344, write 0xAABBCCDD mask 0b0101 -> read 0x11BB33DD.
REQ-021 SHALL cover: same-cycle read/write of 0x0 over 0x5, mask 0xF -> 0x5 (policy 0) or 0x0 (policy 1).
REQ-022 SHALL cover: clr_start, clr_all=0, clr_row=3 -> clr_busy KMAX+1 cycles, clr_done one pulse, row 3 reads 0, row 2 intact.
REQ-023 SHALL cover: read channel 1 with row=M -> rd_data=0, rd_err[1]=1, err_sticky=1; err_clr -> err_sticky=0.
REQ-024 SHALL cover: rst_n low mid-CLR -> all outputs at reset values next cycle; a new clr_start is accepted.
